// File: rtl/tmr_fault_manager.sv
// tmr_fault_manager: classifies TMR voter disagreements, masks a persistently faulty core, sequences restart, halts on loss of majority
//   clk, rst_in (async active-low)
//   Voter_state[1:0] 00 agree / 01 A / 10 B / 11 C out-voted; vote_fail no majority; scrub_req restart request
//   core_mask[2:0] excluded cores; core_rst_n core reset; sys_halt fatal flag; err_irq classification pulse
//   fault_cnt saturating event count; fm_state 00 NORMAL / 01 DEGRADED / 10 RECOVER / 11 FATAL
module tmr_fault_manager #(
    parameter int FAULT_THRESH = 4,
    parameter int RST_CYCLES   = 8,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic [1:0]       Voter_state,
    input  logic             vote_fail,
    input  logic             scrub_req,
    output logic [2:0]       core_mask,
    output logic             core_rst_n,
    output logic             sys_halt,
    output logic             err_irq,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [1:0]       fm_state
);
    typedef enum logic [1:0] {NORMAL = 2'b00, DEGRADED = 2'b01, RECOVER = 2'b10, FATAL = 2'b11} state_t;
    localparam int RUN_W = $clog2(FAULT_THRESH + 1);
    localparam int TMR_W = $clog2(RST_CYCLES + 1);
    localparam logic [RUN_W-1:0] THR = RUN_W'(FAULT_THRESH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RST_CYCLES - 1);
    state_t             state_q, state_d;
    logic [2:0]         mask_q, mask_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [1:0]         run_core_q, run_core_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               irq_q, irq_d;
    logic               trans, pers;
    logic [1:0]         idx;
    logic [CNT_W:0]     sum;
    assign idx = Voter_state - 2'd1;
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        run_d      = run_q;
        run_core_d = run_core_q;
        tmr_d      = tmr_q;
        irq_d      = 1'b0;
        trans      = 1'b0;
        pers       = 1'b0;
        case (state_q)
            NORMAL: begin
                if (vote_fail) begin
                    state_d = FATAL;
                    irq_d   = 1'b1;
                    run_d   = '0;
                end else if (Voter_state == 2'b00) begin
                    trans = run_q != '0;
                    run_d = '0;
                end else begin
                    // a change of out-voted core ends the previous run and starts a new one
                    trans      = run_q != '0 && run_core_q != Voter_state;
                    run_d      = trans ? RUN_W'(1) : run_q + 1'b1;
                    run_core_d = Voter_state;
                    if (run_d == THR) begin
                        pers         = 1'b1;
                        mask_d[idx]  = 1'b1;
                        state_d      = DEGRADED;
                        run_d        = '0;
                    end
                end
            end
            DEGRADED: begin
                if (vote_fail || (Voter_state != 2'b00 && !mask_q[idx])) begin
                    state_d = FATAL;
                    irq_d   = 1'b1;
                end else if (scrub_req) begin
                    state_d = RECOVER;
                    tmr_d   = '0;
                end
            end
            RECOVER: begin
                run_d   = '0;
                state_d = tmr_q == TMR_LAST ? NORMAL : RECOVER;
                tmr_d   = tmr_q == TMR_LAST ? tmr_q : tmr_q + 1'b1;
            end
            default: ;
        endcase
        // the mask is released during the final reset cycle so the cores restart fully voting
        mask_d = (state_d == RECOVER && tmr_d == TMR_LAST) ? 3'b000 : mask_d;
        irq_d  = irq_d | trans | pers;
        sum    = {1'b0, cnt_q} + (CNT_W+1)'(trans) + (CNT_W+1)'(pers);
        cnt_d  = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= NORMAL;
            mask_q     <= '0;
            run_q      <= '0;
            run_core_q <= '0;
            tmr_q      <= '0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            run_q      <= run_d;
            run_core_q <= run_core_d;
            tmr_q      <= tmr_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
        end
    end
    assign core_mask  = mask_q;
    assign core_rst_n = state_q != RECOVER;
    assign sys_halt   = state_q == FATAL;
    assign err_irq    = irq_q;
    assign fault_cnt  = cnt_q;
    assign fm_state   = state_q;
endmodule

// File: tb/tb_tmr_fault_manager.sv
// tb_tmr_fault_manager: directed self-checking bench for tmr_fault_manager
module tb_tmr_fault_manager;
    logic       clk = 1'b0;
    logic       rst_in = 1'b0;
    logic [1:0] Voter_state = 2'b00;
    logic       vote_fail = 1'b0;
    logic       scrub_req = 1'b0;
    logic [2:0] core_mask;
    logic       core_rst_n;
    logic       sys_halt;
    logic       err_irq;
    logic [7:0] fault_cnt;
    logic [1:0] fm_state;
    int checks = 0;
    int failures = 0;

    tmr_fault_manager #(.FAULT_THRESH(4), .RST_CYCLES(8), .CNT_W(8)) dut (
        .clk(clk), .rst_in(rst_in), .Voter_state(Voter_state), .vote_fail(vote_fail),
        .scrub_req(scrub_req), .core_mask(core_mask), .core_rst_n(core_rst_n),
        .sys_halt(sys_halt), .err_irq(err_irq), .fault_cnt(fault_cnt), .fm_state(fm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic apply(input logic [1:0] vs, input logic vf, input logic sr);
        Voter_state = vs;
        vote_fail   = vf;
        scrub_req   = sr;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Voter_state = 2'b00;
        vote_fail   = 1'b0;
        scrub_req   = 1'b0;
        rst_in      = 1'b0;
        #2;
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        #3;
        checks++; if (fm_state !== 2'b00) begin failures++; $display("FAIL reset_state got=%b exp=00", fm_state); end
        checks++; if (core_mask !== 3'b000) begin failures++; $display("FAIL reset_mask got=%b exp=000", core_mask); end
        checks++; if (core_rst_n !== 1'b1 || sys_halt !== 1'b0 || err_irq !== 1'b0) begin failures++; $display("FAIL reset_flags got rst_n=%b halt=%b irq=%b exp 1 0 0", core_rst_n, sys_halt, err_irq); end
        checks++; if (fault_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", fault_cnt); end
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    task automatic test_transient();
        do_reset();
        apply(2'b01, 0, 0);
        checks++; if (err_irq !== 1'b0 || fault_cnt !== 8'd0) begin failures++; $display("FAIL t1_run got irq=%b cnt=%0d exp irq=0 cnt=0", err_irq, fault_cnt); end
        apply(2'b01, 0, 0);
        apply(2'b00, 0, 0);
        checks++; if (err_irq !== 1'b1 || fault_cnt !== 8'd1) begin failures++; $display("FAIL t1_end got irq=%b cnt=%0d exp irq=1 cnt=1", err_irq, fault_cnt); end
        apply(2'b00, 0, 0);
        checks++; if (err_irq !== 1'b0 || fault_cnt !== 8'd1) begin failures++; $display("FAIL t1_after got irq=%b cnt=%0d exp irq=0 cnt=1", err_irq, fault_cnt); end
        checks++; if (core_mask !== 3'b000 || fm_state !== 2'b00) begin failures++; $display("FAIL t1_state got mask=%b st=%b exp mask=000 st=00", core_mask, fm_state); end
    endtask

    task automatic test_persistent();
        do_reset();
        repeat (3) apply(2'b10, 0, 0);
        checks++; if (fm_state !== 2'b00 || core_mask !== 3'b000) begin failures++; $display("FAIL t2_pre got st=%b mask=%b exp st=00 mask=000", fm_state, core_mask); end
        apply(2'b10, 0, 0);
        checks++; if (core_mask !== 3'b010 || fm_state !== 2'b01) begin failures++; $display("FAIL t2_mask got mask=%b st=%b exp mask=010 st=01", core_mask, fm_state); end
        checks++; if (fault_cnt !== 8'd1 || err_irq !== 1'b1) begin failures++; $display("FAIL t2_cnt got cnt=%0d irq=%b exp cnt=1 irq=1", fault_cnt, err_irq); end
        apply(2'b10, 0, 0);
        apply(2'b10, 0, 0);
        checks++; if (fm_state !== 2'b01 || err_irq !== 1'b0 || fault_cnt !== 8'd1) begin failures++; $display("FAIL t2_hold got st=%b irq=%b cnt=%0d exp st=01 irq=0 cnt=1", fm_state, err_irq, fault_cnt); end
    endtask

    task automatic test_fatal_degraded();
        apply(2'b11, 0, 0);
        checks++; if (fm_state !== 2'b11 || sys_halt !== 1'b1 || err_irq !== 1'b1) begin failures++; $display("FAIL t3_fatal got st=%b halt=%b irq=%b exp st=11 halt=1 irq=1", fm_state, sys_halt, err_irq); end
        checks++; if (core_mask !== 3'b010 || fault_cnt !== 8'd1 || core_rst_n !== 1'b1) begin failures++; $display("FAIL t3_frozen got mask=%b cnt=%0d rst_n=%b exp mask=010 cnt=1 rst_n=1", core_mask, fault_cnt, core_rst_n); end
        apply(2'b00, 0, 1);
        apply(2'b00, 0, 0);
        checks++; if (fm_state !== 2'b11 || sys_halt !== 1'b1 || err_irq !== 1'b0) begin failures++; $display("FAIL t3_scrub got st=%b halt=%b irq=%b exp st=11 halt=1 irq=0", fm_state, sys_halt, err_irq); end
        rst_in = 1'b0;
        #2;
        checks++; if (fm_state !== 2'b00 || sys_halt !== 1'b0 || core_mask !== 3'b000 || fault_cnt !== 8'd0) begin failures++; $display("FAIL t3_async_rst got st=%b halt=%b mask=%b cnt=%0d exp 00 0 000 0", fm_state, sys_halt, core_mask, fault_cnt); end
        @(negedge clk);
        rst_in = 1'b1;
    endtask

    task automatic test_recover();
        int low;
        do_reset();
        repeat (4) apply(2'b10, 0, 0);
        apply(2'b00, 0, 1);
        checks++; if (fm_state !== 2'b10 || core_rst_n !== 1'b0) begin failures++; $display("FAIL t4_enter got st=%b rst_n=%b exp st=10 rst_n=0", fm_state, core_rst_n); end
        low = 0;
        for (int i = 0; i < 20 && core_rst_n === 1'b0; i++) begin
            low++;
            apply(2'b11, 0, i == 2);
        end
        checks++; if (low != 8) begin failures++; $display("FAIL t4_low_cycles got=%0d exp=8", low); end
        checks++; if (fm_state !== 2'b00 || core_mask !== 3'b000 || core_rst_n !== 1'b1) begin failures++; $display("FAIL t4_exit got st=%b mask=%b rst_n=%b exp 00 000 1", fm_state, core_mask, core_rst_n); end
        apply(2'b00, 0, 0);
        checks++; if (fault_cnt !== 8'd1 || err_irq !== 1'b0 || fm_state !== 2'b00) begin failures++; $display("FAIL t4_quiet got cnt=%0d irq=%b st=%b exp 1 0 00", fault_cnt, err_irq, fm_state); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        pulses = 0;
        repeat (3) begin apply(2'b01, 0, 0); pulses += int'(err_irq); end
        apply(2'b11, 0, 0);
        pulses += int'(err_irq);
        checks++; if (err_irq !== 1'b1 || fault_cnt !== 8'd1) begin failures++; $display("FAIL t5_transient got irq=%b cnt=%0d exp irq=1 cnt=1", err_irq, fault_cnt); end
        repeat (3) begin apply(2'b11, 0, 0); pulses += int'(err_irq); end
        repeat (2) begin apply(2'b00, 0, 0); pulses += int'(err_irq); end
        checks++; if (pulses != 2) begin failures++; $display("FAIL t5_pulses got=%0d exp=2", pulses); end
        checks++; if (core_mask !== 3'b100 || fm_state !== 2'b01 || fault_cnt !== 8'd2) begin failures++; $display("FAIL t5_final got mask=%b st=%b cnt=%0d exp 100 01 2", core_mask, fm_state, fault_cnt); end
    endtask

    task automatic test_vote_fail_and_saturation();
        do_reset();
        apply(2'b01, 1, 0);
        checks++; if (fm_state !== 2'b11 || sys_halt !== 1'b1 || err_irq !== 1'b1 || fault_cnt !== 8'd0) begin failures++; $display("FAIL t6_votefail got st=%b halt=%b irq=%b cnt=%0d exp 11 1 1 0", fm_state, sys_halt, err_irq, fault_cnt); end
        do_reset();
        for (int i = 0; i < 300; i++) apply(i % 2 ? 2'b10 : 2'b01, 0, 0);
        apply(2'b00, 0, 0);
        checks++; if (fault_cnt !== 8'd255 || fm_state !== 2'b00) begin failures++; $display("FAIL t6_saturate got cnt=%0d st=%b exp 255 00", fault_cnt, fm_state); end
        apply(2'b01, 0, 0);
        apply(2'b00, 0, 0);
        checks++; if (fault_cnt !== 8'd255 || err_irq !== 1'b1) begin failures++; $display("FAIL t6_hold got cnt=%0d irq=%b exp 255 1", fault_cnt, err_irq); end
    endtask

    initial begin
        test_reset();
        test_transient();
        test_persistent();
        test_fatal_degraded();
        test_recover();
        test_back_to_back();
        test_vote_fail_and_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
